// File: rtl/countdown_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : BCD hours/minutes/seconds countdown timer. A validated
//                packed-BCD preset is loaded, then decremented once per
//                second (TICK_DIV clk cycles) under start/pause/clear
//                control. Optional auto-reload on expiry and a timed alarm
//                level driven from a free-running second tick.
//  Ports       : clk, rst_n (async, active-low)
//                load/preset  - capture {hr10,hr1,F,min10,min1,F,sec10,sec1}
//                start, pause, clear - one-cycle command pulses
//                time_out     - current count, filler nibbles 4'hF
//                running      - high in RUN
//                done         - one-cycle pulse on each expiry
//                alarm        - high for ALARM_SECS seconds after expiry
//                load_err     - one-cycle pulse on a rejected preset
//                state        - IDLE=0, RUN=1, PAUSED=2, EXPIRED=3
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int unsigned TICK_DIV    = 100_000_000,  // clk cycles per second, >= 2
    parameter int unsigned ALARM_SECS  = 10,           // 0 disables alarm
    parameter int unsigned AUTO_RELOAD = 0             // 1 = reload preset on expiry
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] preset,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    output logic [31:0] time_out,
    output logic        running,
    output logic        done,
    output logic        alarm,
    output logic        load_err,
    output logic [1:0]  state
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int AW = $clog2(ALARM_SECS + 2);

    localparam logic [TW-1:0] c_tick_max   = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] c_alarm_load = AW'(ALARM_SECS);
    localparam logic [23:0]   c_cnt_one    = 24'h00_0001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // Count and stored preset are kept as six packed BCD digits
    // {hr10,hr1,min10,min1,sec10,sec1}; filler nibbles only exist on the ports.
    state_t          r_state;
    logic [23:0]     r_cnt;
    logic [23:0]     r_preset;
    logic [TW-1:0]   r_tick;
    logic [TW-1:0]   r_free;
    logic            r_alarm;
    logic [AW-1:0]   r_alarm_cnt;
    logic            r_done;
    logic            r_load_err;

    state_t          w_state_nxt;
    logic [23:0]     w_cnt_nxt;
    logic [23:0]     w_preset_nxt;
    logic [TW-1:0]   w_tick_nxt;
    logic            w_alarm_nxt;
    logic [AW-1:0]   w_alarm_cnt_nxt;
    logic            w_done_nxt;
    logic            w_load_err_nxt;
    logic            w_count_en;

    logic [23:0]     w_preset_digits;
    logic            w_preset_valid;
    logic            w_free_tick;
    logic            w_run_tick;
    logic [23:0]     w_cnt_dec;

    // Filler nibbles of the preset carry no information.
    logic            w_unused;
    assign w_unused = ^{preset[23:20], preset[11:8]};

    assign w_preset_digits = {preset[31:24], preset[19:12], preset[7:0]};
    assign w_preset_valid  = (preset[31:28] <= 4'd9) && (preset[27:24] <= 4'd9) &&
                             (preset[19:16] <= 4'd5) && (preset[15:12] <= 4'd9) &&
                             (preset[7:4]   <= 4'd5) && (preset[3:0]   <= 4'd9);

    assign w_free_tick = (r_free == c_tick_max);
    assign w_run_tick  = (r_state == ST_RUN) && (r_tick == c_tick_max);

    // ------------------------------------------------------------------
    // BCD borrow chain. Tens-of-seconds and tens-of-minutes wrap to 5,
    // all other digits wrap to 9. Only used when the count is non-zero.
    // ------------------------------------------------------------------
    always_comb begin : p_bcd_dec
        logic       w_borrow;
        logic [3:0] w_dig;
        w_cnt_dec = r_cnt;
        w_borrow  = 1'b1;
        w_dig     = 4'd0;
        for (int i = 0; i < 6; i++) begin
            w_dig = r_cnt[4*i +: 4];
            if (w_borrow) begin
                if (w_dig == 4'd0) begin
                    w_dig = ((i == 1) || (i == 3)) ? 4'd5 : 4'd9;
                end else begin
                    w_dig    = w_dig - 4'd1;
                    w_borrow = 1'b0;
                end
            end
            w_cnt_dec[4*i +: 4] = w_dig;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath. Commands are strictly prioritised
    // clear > load > start > pause; the highest pulse present consumes the
    // cycle even when it has no effect. Counting continues on any RUN cycle
    // not cleared, including the cycle a pause lands on, so the partial
    // second up to and including the pause edge is kept.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_preset_nxt    = r_preset;
        w_tick_nxt      = r_tick;
        w_alarm_nxt     = r_alarm;
        w_alarm_cnt_nxt = r_alarm_cnt;
        w_done_nxt      = 1'b0;
        w_load_err_nxt  = 1'b0;
        w_count_en      = 1'b0;

        // Alarm lifetime is measured on the free-running second tick.
        if (r_alarm && w_free_tick) begin
            if (r_alarm_cnt <= AW'(1)) begin
                w_alarm_nxt = 1'b0;
            end else begin
                w_alarm_cnt_nxt = r_alarm_cnt - AW'(1);
            end
        end

        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 24'd0;
            w_tick_nxt  = '0;
            w_alarm_nxt = 1'b0;
        end else begin
            w_count_en = (r_state == ST_RUN);
            if (load) begin
                if (r_state != ST_RUN) begin
                    if (w_preset_valid) begin
                        w_cnt_nxt    = w_preset_digits;
                        w_preset_nxt = w_preset_digits;
                        w_tick_nxt   = '0;
                        w_alarm_nxt  = 1'b0;
                        w_state_nxt  = ST_IDLE;
                    end else begin
                        w_load_err_nxt = 1'b1;
                    end
                end
            end else if (start) begin
                if ((r_state != ST_RUN) && (r_cnt != 24'd0)) begin
                    // Resuming from PAUSED keeps the partial second.
                    if (r_state != ST_PAUSED) begin
                        w_tick_nxt = '0;
                    end
                    w_state_nxt = ST_RUN;
                    w_alarm_nxt = 1'b0;
                end
            end else if (pause) begin
                if (r_state == ST_RUN) begin
                    w_state_nxt = ST_PAUSED;
                end
            end
        end

        if (w_count_en) begin
            if (!w_run_tick) begin
                w_tick_nxt = r_tick + TW'(1);
            end else begin
                w_tick_nxt = '0;
                if (r_cnt == 24'd0) begin
                    // Zero count in RUN only exists with auto-reload: the
                    // expired second has elapsed, restart from the preset.
                    w_cnt_nxt = r_preset;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                    if (r_cnt == c_cnt_one) begin
                        w_done_nxt = 1'b1;
                        if (ALARM_SECS != 0) begin
                            w_alarm_nxt     = 1'b1;
                            w_alarm_cnt_nxt = c_alarm_load;
                        end
                        if (AUTO_RELOAD == 0) begin
                            w_state_nxt = ST_EXPIRED;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 24'd0;
            r_preset    <= 24'd0;
            r_tick      <= '0;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
            r_done      <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_preset    <= w_preset_nxt;
            r_tick      <= w_tick_nxt;
            r_alarm     <= w_alarm_nxt;
            r_alarm_cnt <= w_alarm_cnt_nxt;
            r_done      <= w_done_nxt;
            r_load_err  <= w_load_err_nxt;
        end
    end

    // Free-running second divider, independent of the countdown state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_free <= '0;
        end else begin
            r_free <= w_free_tick ? '0 : r_free + TW'(1);
        end
    end

    assign time_out = {r_cnt[23:16], 4'hF, r_cnt[15:8], 4'hF, r_cnt[7:0]};
    assign running  = (r_state == ST_RUN);
    assign done     = r_done;
    assign alarm    = r_alarm;
    assign load_err = r_load_err;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Self-checking bench for countdown_timer. Three instances
//                share one stimulus stream: (AR=0, ALARM=3), (AR=1, ALARM=2)
//                and (AR=0, ALARM=0), all with TICK_DIV=4. Every cycle each
//                instance is compared against a seconds-based reference
//                model; directed vectors and sequences add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    localparam int TD = 4;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [31:0] preset;
    logic        start;
    logic        pause;
    logic        clear;

    logic [31:0] time_out [3];
    logic        running  [3];
    logic        done     [3];
    logic        alarm    [3];
    logic        load_err [3];
    logic [1:0]  state    [3];

    int n_checks;
    int n_errors;

    countdown_timer #(.TICK_DIV(TD), .ALARM_SECS(3), .AUTO_RELOAD(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .load(load), .preset(preset), .start(start),
        .pause(pause), .clear(clear), .time_out(time_out[0]), .running(running[0]),
        .done(done[0]), .alarm(alarm[0]), .load_err(load_err[0]), .state(state[0]));

    countdown_timer #(.TICK_DIV(TD), .ALARM_SECS(2), .AUTO_RELOAD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .preset(preset), .start(start),
        .pause(pause), .clear(clear), .time_out(time_out[1]), .running(running[1]),
        .done(done[1]), .alarm(alarm[1]), .load_err(load_err[1]), .state(state[1]));

    countdown_timer #(.TICK_DIV(TD), .ALARM_SECS(0), .AUTO_RELOAD(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .load(load), .preset(preset), .start(start),
        .pause(pause), .clear(clear), .time_out(time_out[2]), .running(running[2]),
        .done(done[2]), .alarm(alarm[2]), .load_err(load_err[2]), .state(state[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Reference model: count held as a plain number of seconds.
    // ------------------------------------------------------------------
    int m_as [3] = '{3, 2, 0};
    int m_ar [3] = '{0, 1, 0};
    int m_st [3];
    int m_sec[3];
    int m_pre[3];
    int m_tick[3];
    int m_free[3];
    int m_left[3];
    bit m_alarm[3];
    bit m_done[3];
    bit m_lerr[3];

    function automatic bit pv_valid(input logic [31:0] p);
        return (p[31:28] <= 4'd9) && (p[27:24] <= 4'd9) && (p[19:16] <= 4'd5) &&
               (p[15:12] <= 4'd9) && (p[7:4] <= 4'd5) && (p[3:0] <= 4'd9);
    endfunction

    function automatic int bcd2sec(input logic [31:0] p);
        int h, m, s;
        h = int'(p[31:28]) * 10 + int'(p[27:24]);
        m = int'(p[19:16]) * 10 + int'(p[15:12]);
        s = int'(p[7:4])   * 10 + int'(p[3:0]);
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic logic [31:0] sec2out(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'hF, 4'(m / 10), 4'(m % 10), 4'hF,
                4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_sec[i] = 0; m_pre[i] = 0; m_tick[i] = 0;
            m_free[i] = 0; m_left[i] = 0; m_alarm[i] = 0; m_done[i] = 0; m_lerr[i] = 0;
        end
    endtask

    task automatic model_step(input logic ld, input logic [31:0] pv, input logic st,
                              input logic ps, input logic cl);
        for (int i = 0; i < 3; i++) begin
            int ost;
            bit ft, rt, run;
            ost = m_st[i];
            ft  = (m_free[i] == TD - 1);
            rt  = (ost == 1) && (m_tick[i] == TD - 1);
            run = (ost == 1) && !cl;
            m_free[i] = ft ? 0 : m_free[i] + 1;
            m_done[i] = 0;
            m_lerr[i] = 0;
            if (m_alarm[i] && ft) begin
                m_left[i]--;
                if (m_left[i] == 0) m_alarm[i] = 0;
            end
            if (cl) begin
                m_st[i] = 0; m_sec[i] = 0; m_tick[i] = 0; m_alarm[i] = 0;
            end else if (ld) begin
                if (ost != 1) begin
                    if (pv_valid(pv)) begin
                        m_sec[i] = bcd2sec(pv); m_pre[i] = m_sec[i];
                        m_tick[i] = 0; m_alarm[i] = 0; m_st[i] = 0;
                    end else begin
                        m_lerr[i] = 1;
                    end
                end
            end else if (st) begin
                if (ost != 1 && m_sec[i] != 0) begin
                    if (ost != 2) m_tick[i] = 0;
                    m_st[i] = 1; m_alarm[i] = 0;
                end
            end else if (ps) begin
                if (ost == 1) m_st[i] = 2;
            end
            if (run) begin
                if (!rt) begin
                    m_tick[i]++;
                end else begin
                    m_tick[i] = 0;
                    if (m_sec[i] == 0) begin
                        m_sec[i] = m_pre[i];
                    end else begin
                        m_sec[i]--;
                        if (m_sec[i] == 0) begin
                            m_done[i] = 1;
                            if (m_as[i] > 0) begin m_alarm[i] = 1; m_left[i] = m_as[i]; end
                            if (m_ar[i] == 0) m_st[i] = 3;
                        end
                    end
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [37:0] dut_vec(input int i);
        return {time_out[i], state[i], running[i], done[i], alarm[i], load_err[i]};
    endfunction

    function automatic logic [37:0] mdl_vec(input int i);
        return {sec2out(m_sec[i]), 2'(m_st[i]), (m_st[i] == 1), m_done[i], m_alarm[i], m_lerr[i]};
    endfunction

    task automatic check_reset(input string tag);
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s dut%0d", tag, i), dut_vec(i), {32'h00F00F00, 6'b0});
    endtask

    task automatic cyc(input logic ld, input logic [31:0] pv, input logic st,
                       input logic ps, input logic cl);
        load = ld; preset = pv; start = st; pause = ps; clear = cl;
        @(posedge clk);
        model_step(ld, pv, st, ps, cl);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
        for (int i = 0; i < 3; i++)
            chk($sformatf("model dut%0d", i), dut_vec(i), mdl_vec(i));
    endtask

    // ------------------------------------------------------------------
    // Directed vector table (expected values are for dut0: AR=0, ALARM=3)
    // ------------------------------------------------------------------
    typedef struct {
        logic        ld;
        logic [31:0] pv;
        logic        st, ps, cl;
        logic [31:0] e_time;
        logic [1:0]  e_state;
        logic        e_done, e_alarm, e_lerr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic ld, input logic [31:0] pv, input logic st, input logic ps,
                       input logic cl, input logic [31:0] et, input logic [1:0] es,
                       input logic ed, input logic ea, input logic el);
        vec_t v;
        v.ld = ld; v.pv = pv; v.st = st; v.ps = ps; v.cl = cl;
        v.e_time = et; v.e_state = es; v.e_done = ed; v.e_alarm = ea; v.e_lerr = el;
        tbl.push_back(v);
    endtask

    task automatic idle(input int n, input logic [31:0] et, input logic [1:0] es, input logic ea);
        for (int k = 0; k < n; k++) add(0, 32'h0, 0, 0, 0, et, es, 0, ea, 0);
    endtask

    int          n_done0, n_done1, bad_state1, frozen_bad;
    logic        r_ld, r_st, r_ps, r_cl;
    logic [31:0] r_pv;
    int          r_sel;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; load = 1'b0; preset = 32'h0; start = 1'b0; pause = 1'b0; clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset("power-on reset");
        rst_n = 1'b1;

        // Edge-by-edge from reset release (free second tick every 4th edge).
        add(1, 32'h00F00F03, 0, 0, 0, 32'h00F00F03, 2'd0, 0, 0, 0);  // load 3 s
        add(0, 32'h0,        1, 0, 0, 32'h00F00F03, 2'd1, 0, 0, 0);  // start
        idle(3, 32'h00F00F03, 2'd1, 0);
        add(0, 32'h0, 0, 0, 0, 32'h00F00F02, 2'd1, 0, 0, 0);         // first decrement
        idle(3, 32'h00F00F02, 2'd1, 0);
        add(0, 32'h0, 0, 0, 0, 32'h00F00F01, 2'd1, 0, 0, 0);
        idle(3, 32'h00F00F01, 2'd1, 0);
        add(0, 32'h0, 0, 0, 0, 32'h00F00F00, 2'd3, 1, 1, 0);         // expiry
        add(1, 32'h00F00F60, 0, 0, 0, 32'h00F00F00, 2'd3, 0, 1, 1);  // invalid sec10
        add(0, 32'h0,        0, 0, 0, 32'h00F00F00, 2'd3, 0, 1, 0);
        add(0, 32'h0,        1, 0, 0, 32'h00F00F00, 2'd3, 0, 1, 0);  // start at 0 ignored
        add(1, 32'h10F00F00, 0, 0, 0, 32'h10F00F00, 2'd0, 0, 0, 0);  // 10:00:00
        add(0, 32'h0,        1, 0, 0, 32'h10F00F00, 2'd1, 0, 0, 0);
        idle(3, 32'h10F00F00, 2'd1, 0);
        add(0, 32'h0, 0, 0, 0, 32'h09F59F59, 2'd1, 0, 0, 0);         // full borrow chain
        add(1, 32'h00F00F05, 0, 0, 0, 32'h09F59F59, 2'd1, 0, 0, 0);  // load in RUN ignored
        add(1, 32'h00F00F05, 1, 0, 1, 32'h00F00F00, 2'd0, 0, 0, 0);  // clear wins
        add(1, 32'h01F00F00, 0, 0, 0, 32'h01F00F00, 2'd0, 0, 0, 0);
        add(0, 32'h0,        1, 0, 0, 32'h01F00F00, 2'd1, 0, 0, 0);
        idle(3, 32'h01F00F00, 2'd1, 0);
        add(0, 32'h0, 0, 0, 0, 32'h00F59F59, 2'd1, 0, 0, 0);
        add(0, 32'h0, 0, 0, 1, 32'h00F00F00, 2'd0, 0, 0, 0);

        foreach (tbl[k]) begin
            cyc(tbl[k].ld, tbl[k].pv, tbl[k].st, tbl[k].ps, tbl[k].cl);
            chk($sformatf("vec%0d time_out", k), time_out[0], tbl[k].e_time);
            chk($sformatf("vec%0d flags", k),
                {state[0], running[0], done[0], alarm[0], load_err[0]},
                {tbl[k].e_state, (tbl[k].e_state == 2'd1), tbl[k].e_done,
                 tbl[k].e_alarm, tbl[k].e_lerr});
        end

        // Pause two cycles into a second, hold, resume.
        cyc(0, 32'h0, 0, 0, 1);
        cyc(1, 32'h00F00F05, 0, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);
        cyc(0, 32'h0, 0, 0, 0);
        cyc(0, 32'h0, 0, 1, 0);
        chk("pause state", state[0], 2'd2);
        frozen_bad = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(0, 32'h0, 0, 0, 0);
            if (time_out[0] !== 32'h00F00F05 || state[0] !== 2'd2) frozen_bad++;
        end
        chk("paused count frozen", frozen_bad, 0);
        cyc(0, 32'h0, 1, 0, 0);
        chk("resume state", state[0], 2'd1);
        cyc(0, 32'h0, 0, 0, 0);
        chk("resume +1 no decrement", time_out[0], 32'h00F00F05);
        cyc(0, 32'h0, 0, 0, 0);
        chk("resume +2 decrement", time_out[0], 32'h00F00F04);

        // Auto-reload: 00:00:02 expires every 3 ticks on dut1, once on dut0.
        cyc(0, 32'h0, 0, 0, 1);
        cyc(1, 32'h00F00F02, 0, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);
        n_done0 = 0; n_done1 = 0; bad_state1 = 0;
        for (int k = 1; k <= 24; k++) begin
            cyc(0, 32'h0, 0, 0, 0);
            if (done[0]) n_done0++;
            if (done[1]) n_done1++;
            if (state[1] !== 2'd1) bad_state1++;
        end
        chk("autoreload done count", n_done1, 2);
        chk("autoreload stays RUN", bad_state1, 0);
        chk("single-shot done count", n_done0, 1);
        chk("single-shot expired", state[0], 2'd3);
        chk("alarm disabled instance", alarm[2], 1'b0);

        // Asynchronous reset in the middle of a run.
        cyc(0, 32'h0, 0, 0, 1);
        cyc(1, 32'h00F00F09, 0, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);
        repeat (5) cyc(0, 32'h0, 0, 0, 0);
        chk("pre-reset running", running[0], 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset("async reset");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomised commands against the reference model.
        for (int k = 0; k < 3000; k++) begin
            r_cl  = ($urandom_range(0, 39) == 0);
            r_ld  = ($urandom_range(0, 9) == 0);
            r_st  = ($urandom_range(0, 5) == 0);
            r_ps  = ($urandom_range(0, 11) == 0);
            r_sel = int'($urandom_range(0, 9));
            if (r_sel == 0)      r_pv = $urandom;
            else if (r_sel == 1) r_pv = 32'h00F01F00 | 32'($urandom_range(0, 9));
            else                 r_pv = 32'h00F00F00 | 32'($urandom_range(0, 9));
            cyc(r_ld, r_pv, r_st, r_ps, r_cl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
